nibble_packer: RTL and testbench
================================

Name: nibble_packer

Overview:
- Downstream stage of the nibble selector. Consumes the registered 4-bit nibble stream and reassembles it into 32-bit words.
- Each word is offered to the next stage over a valid/ready handshake.
- A one-word output holding register plus the accumulator let a full word wait on a stalled consumer while the selector is back-pressured cleanly.
- Flush emits a zero-padded partial word.

Parameters:
NIBBLES, 8, nibbles per output word; word width is 4*NIBBLES (32 at default)
CNT_W, 4, width of nibble counters; must hold values 0..NIBBLES

Ports:
clk  input  1  rising-edge clock
reset_L  input  1  asynchronous active-low reset
nibble_in  input  4  nibble from selector
nibble_valid  input  1  nibble_in is valid this cycle
nibble_ready  output  1  packer can accept a nibble this cycle
flush  input  1  close current partial word, one-cycle pulse
word_out  output  4*NIBBLES  assembled word
word_nibbles  output  CNT_W  number of valid nibbles in word_out (1..NIBBLES)
word_valid  output  1  word_out/word_nibbles valid
word_ready  input  1  consumer accepts word
nib_count  output  CNT_W  nibbles currently held in the accumulator

Behaviour:
- Reset (reset_L=0, async): word_out=0, word_nibbles=0, word_valid=0, nib_count=0, accumulator=0, state=FILL. nibble_ready=1 once reset deasserts.
- Accept: a nibble is accepted on a rising edge with nibble_valid && nibble_ready.
- Packing order: nibble k (k=0 first) is written to accumulator bits [4k+3:4k], LSB first. This matches the selector's sel*4 indexing.
- Outgoing word: taken when word_valid && word_ready. word_out and word_nibbles stay stable while word_valid=1 && word_ready=0.
- Output register "free this cycle" = !word_valid || word_ready.
- State FILL (nibble_ready=1):
  - Accept with nib_count < NIBBLES-1: store nibble; nib_count+1.
  - Accept of nibble NIBBLES-1, output free: next edge word_out<=completed word (including this nibble), word_nibbles<=NIBBLES, word_valid<=1, accumulator<=0, nib_count<=0. Stay in FILL. Latency: last nibble accepted -> word_valid high 1 cycle later.
  - Accept of nibble NIBBLES-1, output not free: store nibble; nib_count<=NIBBLES; go to STALL.
- State STALL (nibble_ready=0; nibble_in ignored):
  - When output becomes free: next edge transfer accumulator to word_out, word_nibbles<=NIBBLES, word_valid<=1, clear accumulator and nib_count, return to FILL.
  - Back-to-back: with word_ready held 1, the transfer happens in the same edge the old word is taken. There is no bubble.
- Output drain: word taken and no new word loaded -> word_valid<=0 next edge.
- Flush, in FILL only:
  - Effective count = nib_count + (nibble accepted this cycle ? 1 : 0). A simultaneous nibble is included in the flushed word.
  - Effective count == 0: flush ignored.
  - Effective count == NIBBLES: handled as a normal word completion (goes to STALL if output not free).
  - 0 < effective count < NIBBLES, output free: next edge word_out<=accumulator with upper nibbles zero, word_nibbles<=effective count, word_valid<=1, clear accumulator.
  - 0 < effective count < NIBBLES, output not free: latch a pending-flush flag, deassert nibble_ready, and emit the partial word as soon as output is free (same rule as STALL).
- Flush in STALL: ignored. The word is already closed.
- Invariant: nib_count never exceeds NIBBLES. No nibble is ever dropped or duplicated.
- Reset mid-operation: all held data is discarded immediately, without waiting for a clock edge.

Test Plan:
- Reset, then nibbles 1,2,3,4,5,6,7,8 on consecutive cycles with word_ready=1 -> one cycle after nibble 8: word_valid=1, word_out=32'h87654321, word_nibbles=8, nib_count=0.
- word_ready=0: send 8 nibbles A..A, then nibbles 0..7 -> first word 32'hAAAAAAAA held; second word fills accumulator; nibble_ready=0 with nib_count=8. Raise word_ready -> 32'hAAAAAAAA taken, next cycle word_out=32'h76543210, nibble_ready=1.
- Nibbles 5,6,7, then flush with no nibble -> word_out=32'h00000765, word_nibbles=3, word_valid=1.
- Nibble 9 accepted in the same cycle as flush after nibbles 1,2 -> word_out=32'h00000921, word_nibbles=3.
- Flush with nib_count=0 and no nibble -> word_valid stays 0, no output change.
- Assert reset_L=0 asynchronously mid-word (nib_count=5) and in STALL -> all outputs 0 immediately. After release, 8 new nibbles produce a clean word with no residue from before reset.

Source files
------------

// File: rtl/nibble_packer.sv
// rtl/nibble_packer.sv - packs a 4-bit nibble stream into words behind a one-word valid/ready output register
module nibble_packer #(
  parameter int NIBBLES = 8,
  parameter int CNT_W   = 4
) (
  input  logic                   clk,
  input  logic                   reset_L,
  input  logic [3:0]             nibble_in,
  input  logic                   nibble_valid,
  output logic                   nibble_ready,
  input  logic                   flush,
  output logic [4*NIBBLES-1:0]   word_out,
  output logic [CNT_W-1:0]       word_nibbles,
  output logic                   word_valid,
  input  logic                   word_ready,
  output logic [CNT_W-1:0]       nib_count
);

  localparam int W = 4 * NIBBLES;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

  typedef enum logic {FILL, STALL} state_t;

  state_t             state, state_nx;
  logic [W-1:0]       acc, acc_nx, acc_ins, word_nx;
  logic [CNT_W-1:0]   cnt_nx, wn_nx, eff;
  logic               wv_nx, accept, out_free, close;

  assign nibble_ready = (state == FILL);
  assign accept       = nibble_valid && nibble_ready;
  assign out_free     = !word_valid || word_ready;
  assign eff          = nib_count + {{(CNT_W-1){1'b0}}, accept};
  // A word closes on its last nibble or on a flush that has something to emit.
  assign close        = (accept && nib_count == LAST) || (flush && eff != '0);

  always_comb begin
    acc_ins = acc;
    for (int k = 0; k < NIBBLES; k++) begin
      if (accept && nib_count == CNT_W'(k)) acc_ins[4*k +: 4] = nibble_in;
    end
  end

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = nib_count;
    word_nx  = word_out;
    wn_nx    = word_nibbles;
    wv_nx    = word_valid;
    if (word_valid && word_ready) wv_nx = 1'b0;
    case (state)
      FILL: begin
        if (close && out_free) begin
          word_nx = acc_ins;
          wn_nx   = eff;
          wv_nx   = 1'b1;
          acc_nx  = '0;
          cnt_nx  = '0;
        end else if (close) begin
          // Closed word (full or flushed partial) waits in the accumulator.
          acc_nx   = acc_ins;
          cnt_nx   = eff;
          state_nx = STALL;
        end else begin
          acc_nx = acc_ins;
          cnt_nx = eff;
        end
      end
      STALL: begin
        if (out_free) begin
          word_nx  = acc;
          wn_nx    = nib_count;
          wv_nx    = 1'b1;
          acc_nx   = '0;
          cnt_nx   = '0;
          state_nx = FILL;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state        <= FILL;
      acc          <= '0;
      nib_count    <= '0;
      word_out     <= '0;
      word_nibbles <= '0;
      word_valid   <= 1'b0;
    end else begin
      state        <= state_nx;
      acc          <= acc_nx;
      nib_count    <= cnt_nx;
      word_out     <= word_nx;
      word_nibbles <= wn_nx;
      word_valid   <= wv_nx;
    end
  end

endmodule

// File: tb/tb_nibble_packer.sv
// tb/tb_nibble_packer.sv - self-checking bench for nibble_packer
module tb_nibble_packer;

  logic        clk = 1'b0;
  logic        reset_L = 1'b0;
  logic [3:0]  nibble_in = '0;
  logic        nibble_valid = 1'b0;
  logic        nibble_ready;
  logic        flush = 1'b0;
  logic [31:0] word_out;
  logic [3:0]  word_nibbles;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic [3:0]  nib_count;

  int checks = 0;
  int errors = 0;

  nibble_packer #(.NIBBLES(8), .CNT_W(4)) dut (
    .clk(clk), .reset_L(reset_L), .nibble_in(nibble_in), .nibble_valid(nibble_valid),
    .nibble_ready(nibble_ready), .flush(flush), .word_out(word_out),
    .word_nibbles(word_nibbles), .word_valid(word_valid), .word_ready(word_ready),
    .nib_count(nib_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [3:0]  n;
    logic        f;
    logic        r;
    logic        ev;
    logic [31:0] ew;
    logic [3:0]  en;
    logic [3:0]  ec;
    logic        er;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [3:0] n, logic f, logic r,
                              logic ev, logic [31:0] ew, logic [3:0] en,
                              logic [3:0] ec, logic er);
    vec_t x;
    x = '{v, n, f, r, ev, ew, en, ec, er};
    return x;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [3:0] n, logic f, logic r);
    nibble_valid = v;
    nibble_in    = n;
    flush        = f;
    word_ready   = r;
  endtask

  task automatic do_reset();
    #2 reset_L = 1'b0;
    #1;
    chk("rst_word", word_out, 32'h0);
    chk("rst_wn", {28'h0, word_nibbles}, 32'h0);
    chk("rst_wv", {31'h0, word_valid}, 32'h0);
    chk("rst_cnt", {28'h0, nib_count}, 32'h0);
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    #1 reset_L = 1'b1;
    step();
    chk("rst_nready", {31'h0, nibble_ready}, 32'h1);
  endtask

  // Reference model: accepted nibbles gathered into words at stream level.
  logic [3:0]  cur[$];
  logic [35:0] expq[$];

  function automatic logic [35:0] pack(logic [3:0] q[$]);
    logic [31:0] w;
    w = 32'h0;
    for (int k = 0; k < q.size(); k++) w = w + (32'(q[k]) << (4 * k));
    return {4'(q.size()), w};
  endfunction

  task automatic rand_cycle(logic v, logic [3:0] n, logic f, logic r);
    logic        p_rdy, p_acc, p_take, p_hold;
    logic [31:0] p_word;
    logic [35:0] e;
    drive(v, n, f, r);
    #1;
    p_rdy  = nibble_ready;
    p_acc  = v && nibble_ready;
    p_take = word_valid && word_ready;
    p_hold = word_valid && !word_ready;
    p_word = word_out;
    step();
    if (p_take) begin
      if (expq.size() == 0) begin
        chk("rnd_unexpected_word", 32'h1, 32'h0);
      end else begin
        e = expq.pop_front();
        chk("rnd_word", p_word, e[31:0]);
      end
    end
    if (p_hold) chk("rnd_hold", word_out, p_word);
    if (p_rdy) begin
      if (p_acc) cur.push_back(n);
      if (cur.size() == 8 || (f && cur.size() > 0)) begin
        expq.push_back(pack(cur));
        cur = {};
      end
    end
    if (nibble_ready) chk("rnd_cnt", {28'h0, nib_count}, 32'(cur.size()));
    if (word_valid && expq.size() > 0)
      chk("rnd_wn", {28'h0, word_nibbles}, {28'h0, expq[0][35:32]});
  endtask

  initial begin
    // Reset values while reset is held.
    #3;
    chk("init_word", word_out, 32'h0);
    chk("init_wv", {31'h0, word_valid}, 32'h0);
    chk("init_cnt", {28'h0, nib_count}, 32'h0);
    #3 reset_L = 1'b1;
    step();

    for (int i = 1; i <= 7; i++)
      vecs.push_back(mk(1, 4'(i), 0, 1, 0, 32'h0, 4'd0, 4'(i), 1));
    vecs.push_back(mk(1, 4'h8, 0, 1, 1, 32'h87654321, 4'd8, 4'd0, 1));
    vecs.push_back(mk(0, 4'h0, 0, 1, 0, 32'h87654321, 4'd8, 4'd0, 1));
    vecs.push_back(mk(1, 4'h5, 0, 1, 0, 32'h87654321, 4'd8, 4'd1, 1));
    vecs.push_back(mk(1, 4'h6, 0, 1, 0, 32'h87654321, 4'd8, 4'd2, 1));
    vecs.push_back(mk(1, 4'h7, 0, 1, 0, 32'h87654321, 4'd8, 4'd3, 1));
    vecs.push_back(mk(0, 4'h0, 1, 1, 1, 32'h00000765, 4'd3, 4'd0, 1));
    vecs.push_back(mk(0, 4'h0, 0, 1, 0, 32'h00000765, 4'd3, 4'd0, 1));
    vecs.push_back(mk(1, 4'h1, 0, 1, 0, 32'h00000765, 4'd3, 4'd1, 1));
    vecs.push_back(mk(1, 4'h2, 0, 1, 0, 32'h00000765, 4'd3, 4'd2, 1));
    vecs.push_back(mk(1, 4'h9, 1, 1, 1, 32'h00000921, 4'd3, 4'd0, 1));
    vecs.push_back(mk(0, 4'h0, 0, 1, 0, 32'h00000921, 4'd3, 4'd0, 1));
    vecs.push_back(mk(0, 4'h0, 1, 1, 0, 32'h00000921, 4'd3, 4'd0, 1));
    vecs.push_back(mk(0, 4'h0, 1, 0, 0, 32'h00000921, 4'd3, 4'd0, 1));

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].n, vecs[i].f, vecs[i].r);
      step();
      chk($sformatf("vec%0d_wv", i), {31'h0, word_valid}, {31'h0, vecs[i].ev});
      chk($sformatf("vec%0d_word", i), word_out, vecs[i].ew);
      chk($sformatf("vec%0d_wn", i), {28'h0, word_nibbles}, {28'h0, vecs[i].en});
      chk($sformatf("vec%0d_cnt", i), {28'h0, nib_count}, {28'h0, vecs[i].ec});
      chk($sformatf("vec%0d_nready", i), {31'h0, nibble_ready}, {31'h0, vecs[i].er});
    end

    // Stalled consumer: second word waits in the accumulator, then moves with no bubble.
    for (int i = 0; i < 8; i++) begin drive(1, 4'hA, 0, 0); step(); end
    for (int i = 0; i < 8; i++) begin drive(1, 4'(i), 0, 0); step(); end
    chk("stall_word", word_out, 32'hAAAAAAAA);
    chk("stall_nready", {31'h0, nibble_ready}, 32'h0);
    chk("stall_cnt", {28'h0, nib_count}, 32'h8);
    drive(1, 4'hF, 1, 0); step();
    chk("stall_ignore", {28'h0, nib_count}, 32'h8);
    drive(0, 4'h0, 0, 1); step();
    chk("b2b_word", word_out, 32'h76543210);
    chk("b2b_wv", {31'h0, word_valid}, 32'h1);
    chk("b2b_nready", {31'h0, nibble_ready}, 32'h1);
    chk("b2b_cnt", {28'h0, nib_count}, 32'h0);
    drive(0, 4'h0, 0, 1); step();
    chk("drain_wv", {31'h0, word_valid}, 32'h0);

    // Pending flush behind a held word.
    for (int i = 0; i < 8; i++) begin drive(1, 4'h3, 0, 0); step(); end
    drive(1, 4'h1, 0, 0); step();
    drive(1, 4'h2, 1, 0); step();
    chk("pflush_nready", {31'h0, nibble_ready}, 32'h0);
    chk("pflush_cnt", {28'h0, nib_count}, 32'h2);
    drive(0, 4'h0, 0, 1); step();
    chk("pflush_word", word_out, 32'h00000021);
    chk("pflush_wn", {28'h0, word_nibbles}, 32'h2);
    drive(0, 4'h0, 0, 1); step();

    // Async reset mid-word and in STALL, then a clean word.
    for (int i = 0; i < 5; i++) begin drive(1, 4'hC, 0, 1); step(); end
    chk("mid_cnt", {28'h0, nib_count}, 32'h5);
    do_reset();
    for (int i = 0; i < 16; i++) begin drive(1, 4'hE, 0, 0); step(); end
    chk("pre_rst_stall", {31'h0, nibble_ready}, 32'h0);
    do_reset();
    for (int i = 0; i < 8; i++) begin drive(1, 4'(8 - i), 0, 1); step(); end
    chk("post_rst_word", word_out, 32'h12345678);
    chk("post_rst_wn", {28'h0, word_nibbles}, 32'h8);
    chk("post_rst_cnt", {28'h0, nib_count}, 32'h0);
    drive(0, 4'h0, 0, 1); step();

    // Randomized traffic against the stream-level model.
    cur = {};
    expq = {};
    for (int c = 0; c < 3000; c++)
      rand_cycle($urandom_range(0, 9) < 7, 4'($urandom), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) < 6);
    for (int c = 0; c < 30; c++) rand_cycle(1'b0, 4'h0, 1'b1, 1'b1);
    chk("rnd_drained", 32'(expq.size()), 32'h0);
    chk("rnd_residue", 32'(cur.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
